servant_ecp5_rst_ctrl: RTL

//  Board-level reset controller sitting directly upstream of servant_ecp5_clock_gen: drives its i_rst.

---
 rtl/servant_ecp5_rst_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/servant_ecp5_rst_ctrl.sv
// servant_ecp5_rst_ctrl
// Board-level reset controller feeding servant_ecp5_clock_gen i_rst.
// Synchronises and debounces the raw push-button, synchronises the PLL lock
// flag, and sequences a clean active-high reset: HOLD -> WAIT_LOCK -> RUN.
// Re-enters HOLD on a debounced button press or on loss of PLL lock.
//
// Optional feature macro: SERVANT_RST_CTRL_COUNT_EN
//   When defined, adds o_rst_count, a saturating count of RUN->HOLD exits
//   caused by a button press.
//
// Ports
//   i_clk        in   1  board oscillator clock
//   i_rst_n      in   1  asynchronous active-low reset
//   i_btn_n      in   1  raw button, asynchronous, 0 = pressed
//   i_pll_lock   in   1  PLL lock flag, asynchronous, 1 = locked
//   o_rst        out  1  registered active-high reset to clock_gen
//   o_btn_clean  out  1  debounced button level, 0 = pressed
//   o_state      out  2  current state: 0 HOLD, 1 WAIT_LOCK, 2 RUN
//   o_rst_count  out  8  (macro only) button-caused RUN->HOLD count
//
// state      | meaning
// -----------+-------------------------------------------------------------
// HOLD       | reset asserted, counting released-button cycles to minimum
// WAIT_LOCK  | minimum width done, reset still asserted until PLL locks
// RUN        | reset released; leaves on button press or lock loss

module servant_ecp5_rst_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RST_HOLD_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_n,
    input  logic       i_pll_lock,
    output logic       o_rst,
    output logic       o_btn_clean,
`ifdef SERVANT_RST_CTRL_COUNT_EN
    output logic [1:0] o_state,
    output logic [7:0] o_rst_count
`else
    output logic [1:0] o_state
`endif
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    logic          btn_m, btn_s;
    logic          lock_m, lock_s;
    logic [DW-1:0] cnt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    state_t        state, state_nxt;

    // Button synchroniser idles released (1), lock synchroniser idles unlocked (0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_m  <= 1'b1;
            btn_s  <= 1'b1;
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            btn_m  <= i_btn_n;
            btn_s  <= btn_m;
            lock_m <= i_pll_lock;
            lock_s <= lock_m;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // clean level, so any agreeing sample restarts the stability window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt         <= '0;
            o_btn_clean <= 1'b1;
        end else if (btn_s == o_btn_clean) begin
            cnt <= '0;
        end else if (cnt == DEB_LAST) begin
            cnt         <= '0;
            o_btn_clean <= btn_s;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        case (state)
            ST_HOLD: begin
                if (!o_btn_clean) begin
                    hcnt_nxt = '0;
                end else if (hcnt == HOLD_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    hcnt_nxt  = '0;
                end else begin
                    hcnt_nxt = hcnt + HW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (!o_btn_clean) begin
                    state_nxt = ST_HOLD;
                    hcnt_nxt  = '0;
                end else if (lock_s) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!o_btn_clean || !lock_s) begin
                    state_nxt = ST_HOLD;
                    hcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_HOLD;
                hcnt_nxt  = '0;
            end
        endcase
    end

    // o_rst is registered from next_state so it changes on the same edge as
    // the state register, with no combinational path to the output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_HOLD;
            hcnt  <= '0;
            o_rst <= 1'b1;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            o_rst <= (state_nxt != ST_RUN);
        end
    end

    assign o_state = state;

`ifdef SERVANT_RST_CTRL_COUNT_EN
    // A simultaneous press and lock loss is attributed to the press.
    logic press_exit;
    assign press_exit = (state == ST_RUN) && (state_nxt == ST_HOLD) && !o_btn_clean;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rst_count <= 8'd0;
        end else if (press_exit && (o_rst_count != 8'hFF)) begin
            o_rst_count <= o_rst_count + 8'd1;
        end
    end
`endif

endmodule
